fft_ser_sched: RTL and testbench

Frame-locking scheduler that shares one 4:1 parallel-to-serial converter between two FFT output requesters. Each requester offers 4-word complex groups over a valid/ready handshake. The block captures the granted group, drives the serializer's START and DR/DI, and emits per-word framing flags aligned with the serial output. It sits between the 32-point FFT output stage(s) and the serializer.

---
 rtl/fft_ser_sched_if.sv | 16 +
 rtl/fft_ser_sched.sv | 87 ++++++++
 tb/tb_fft_ser_sched.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/fft_ser_sched_if.sv
// fft_ser_sched_if: requester, serializer and framing signals of the scheduler
interface fft_ser_sched_if #(parameter int nb = 16);
  logic            IN0_VAL, IN0_RDY, IN1_VAL, IN1_RDY, HOLD;
  logic [4*nb-1:0] IN0_DR, IN0_DI, IN1_DR, IN1_DI;
  logic            SER_START;
  logic [4*nb-1:0] SER_DR, SER_DI;
  logic            OUT_VAL, OUT_SRC, OUT_SOF, OUT_EOF, BUSY;
  modport master (
    output IN0_VAL, IN0_DR, IN0_DI, IN1_VAL, IN1_DR, IN1_DI, HOLD,
    input  IN0_RDY, IN1_RDY, SER_START, SER_DR, SER_DI, OUT_VAL, OUT_SRC, OUT_SOF, OUT_EOF, BUSY
  );
  modport slave (
    input  IN0_VAL, IN0_DR, IN0_DI, IN1_VAL, IN1_DR, IN1_DI, HOLD,
    output IN0_RDY, IN1_RDY, SER_START, SER_DR, SER_DI, OUT_VAL, OUT_SRC, OUT_SOF, OUT_EOF, BUSY
  );
endinterface

// File: rtl/fft_ser_sched.sv
// fft_ser_sched: frame-locking round-robin scheduler feeding one shared 4:1 serializer
module fft_ser_sched #(
  parameter int nb  = 16,
  parameter int GPF = 8
) (
  input  logic CLK,
  input  logic RST,
  fft_ser_sched_if.slave bus
);
  localparam int GW = $clog2(GPF);
  localparam logic [GW-1:0] G_LAST = GW'(GPF - 1);
  logic            r_inflight, r_owner, r_last_owner, r_start;
  logic            r_grp_src, r_grp_first, r_grp_last;
  logic            r_out_val, r_out_src, r_out_sof, r_out_eof, r_busy;
  logic [1:0]      r_beat;
  logic [GW-1:0]   r_gcnt;
  logic [4*nb-1:0] r_ser_dr, r_ser_di;
  logic            w_free, w_bound, w_sel, w_sel_val, w_acc, w_glast;
  // Grant: frame boundary picks by validity then round-robin; mid-frame only the owner may go
  always_comb begin
    w_free    = !r_inflight || (r_beat == 2'd3);
    w_bound   = (r_gcnt == '0);
    w_glast   = (r_gcnt == G_LAST);
    w_sel     = w_bound ? ((bus.IN0_VAL && bus.IN1_VAL) ? !r_last_owner : bus.IN1_VAL) : r_owner;
    w_sel_val = w_sel ? bus.IN1_VAL : bus.IN0_VAL;
    w_acc     = RST && w_free && !bus.HOLD && w_sel_val;
  end
  assign bus.IN0_RDY   = w_acc && !w_sel;
  assign bus.IN1_RDY   = w_acc && w_sel;
  assign bus.SER_START = r_start;
  assign bus.SER_DR    = r_ser_dr;
  assign bus.SER_DI    = r_ser_di;
  assign bus.OUT_VAL   = r_out_val;
  assign bus.OUT_SRC   = r_out_src;
  assign bus.OUT_SOF   = r_out_sof;
  assign bus.OUT_EOF   = r_out_eof;
  assign bus.BUSY      = r_busy;
  // Capture the granted group and track beat, group count and frame ownership
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_inflight   <= 1'b0;
      r_beat       <= '0;
      r_gcnt       <= '0;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
      r_start      <= 1'b0;
      r_grp_src    <= 1'b0;
      r_grp_first  <= 1'b0;
      r_grp_last   <= 1'b0;
      r_ser_dr     <= '0;
      r_ser_di     <= '0;
    end else begin
      r_start <= w_acc;
      if (w_acc) begin
        r_ser_dr    <= w_sel ? bus.IN1_DR : bus.IN0_DR;
        r_ser_di    <= w_sel ? bus.IN1_DI : bus.IN0_DI;
        r_inflight  <= 1'b1;
        r_beat      <= '0;
        r_grp_src   <= w_sel;
        r_grp_first <= w_bound;
        r_grp_last  <= w_glast;
        r_gcnt      <= w_glast ? '0 : r_gcnt + 1'b1;
        if (w_bound) r_owner <= w_sel;
        if (w_glast) r_last_owner <= w_sel;
      end else if (r_inflight) begin
        r_beat <= r_beat + 2'd1;
        if (r_beat == 2'd3) r_inflight <= 1'b0;
      end
    end
  end
  // Framing flags trail the hold beats by one cycle so they line up with the serializer output
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_out_val <= 1'b0;
      r_out_src <= 1'b0;
      r_out_sof <= 1'b0;
      r_out_eof <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_out_val <= r_inflight;
      r_out_src <= r_grp_src;
      r_out_sof <= r_inflight && (r_beat == 2'd0) && r_grp_first;
      r_out_eof <= r_inflight && (r_beat == 2'd3) && r_grp_last;
      r_busy    <= w_acc || (r_busy && !(r_out_eof && !r_inflight));
    end
  end
endmodule

// File: tb/tb_fft_ser_sched.sv
// tb_fft_ser_sched: directed scenarios with an emulated serializer and expected word stream
module tb_fft_ser_sched;
  typedef struct {logic src; logic sof; logic eof; logic [15:0] w;} exp_t;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;
  fft_ser_sched_if #(.nb(16)) ifc();
  fft_ser_sched #(.nb(16), .GPF(8)) dut (.CLK(CLK), .RST(RST), .bus(ifc.slave));
  int checks = 0, errors = 0;
  int k0 = 0, k1 = 0, cyc_n = 0, vcnt = 0, first_v = -1, last_v = -1;
  logic rdy0, rdy1;
  logic [63:0] sh_dr = '0, sh_di = '0;
  exp_t q[$];
  logic acc_log[$];
  // external serializer model: loads on START, then shifts out word3 first
  always @(posedge CLK) begin
    if (ifc.SER_START) begin
      sh_dr <= ifc.SER_DR;
      sh_di <= ifc.SER_DI;
    end else begin
      sh_dr <= sh_dr << 16;
      sh_di <= sh_di << 16;
    end
  end
  function automatic logic [63:0] grp(input logic r, input int k);
    logic [15:0] b;
    b = 16'(16 * k) + (r ? 16'h1000 : 16'h0000);
    return {b + 16'd4, b + 16'd3, b + 16'd2, b + 16'd1};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic push_grp(input logic r, input int k);
    logic [15:0] b;
    b = 16'(16 * k) + (r ? 16'h1000 : 16'h0000);
    for (int j = 4; j >= 1; j--)
      q.push_back('{src: r, sof: (k == 0 && j == 4), eof: (k == 7 && j == 1), w: b + 16'(j)});
    acc_log.push_back(r);
  endtask
  task automatic cyc();
    logic a0, a1;
    exp_t e;
    ifc.IN0_DR = grp(1'b0, k0);
    ifc.IN0_DI = ~grp(1'b0, k0);
    ifc.IN1_DR = grp(1'b1, k1);
    ifc.IN1_DI = ~grp(1'b1, k1);
    #1;
    rdy0 = ifc.IN0_RDY;
    rdy1 = ifc.IN1_RDY;
    a0 = ifc.IN0_VAL & rdy0;
    a1 = ifc.IN1_VAL & rdy1;
    chk("rdy_excl", {rdy0, rdy1} == 2'b11, 1'b0);
    @(posedge CLK);
    if (a0) begin push_grp(1'b0, k0); k0 = (k0 + 1) % 8; end
    if (a1) begin push_grp(1'b1, k1); k1 = (k1 + 1) % 8; end
    @(negedge CLK);
    cyc_n++;
    if (ifc.OUT_VAL) begin
      vcnt++;
      if (first_v < 0) first_v = cyc_n;
      last_v = cyc_n;
      if (q.size() == 0) chk("stream_extra", ifc.OUT_VAL, 1'b0);
      else begin
        e = q.pop_front();
        chk("ser_word", {ifc.OUT_SRC, ifc.OUT_SOF, ifc.OUT_EOF, sh_dr[63:48], sh_di[63:48]},
            {e.src, e.sof, e.eof, e.w, ~e.w});
      end
    end else chk("flags_idle", {ifc.OUT_SOF, ifc.OUT_EOF}, 2'b00);
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_start"}, ifc.SER_START, 1'b0);
    chk({tag, "_ser"}, {ifc.SER_DR, ifc.SER_DI} == '0, 1'b1);
    chk({tag, "_flags"}, {ifc.OUT_VAL, ifc.OUT_SRC, ifc.OUT_SOF, ifc.OUT_EOF, ifc.BUSY}, 5'b0);
    chk({tag, "_rdy"}, {rdy0, rdy1}, 2'b00);
  endtask
  task automatic do_reset(input string tag);
    RST = 1'b0;
    q.delete();
    acc_log.delete();
    k0 = 0;
    k1 = 0;
    cyc();
    chk_reset_outs(tag);
    cyc();
    RST = 1'b1;
    vcnt = 0;
    first_v = -1;
  endtask
  task automatic run_until(input string tag, input int n);
    int g = 0;
    while (acc_log.size() < n && g < 200) begin cyc(); g++; end
    chk(tag, acc_log.size(), n);
  endtask
  task automatic flush(input string tag);
    int g = 0;
    while ((q.size() != 0 || ifc.OUT_VAL) && g < 60) begin cyc(); g++; end
    chk({tag, "_drain"}, q.size(), 0);
    chk({tag, "_busy_end"}, ifc.BUSY, 1'b0);
  endtask
  task automatic chk_log(input string tag, input logic [31:0] pat);
    logic [31:0] got = '0;
    for (int i = 0; i < acc_log.size() && i < 32; i++) got[i] = acc_log[i];
    chk(tag, got, pat);
  endtask
  initial begin
    ifc.IN0_VAL = 1'b1;
    ifc.IN1_VAL = 1'b1;
    ifc.HOLD = 1'b0;
    do_reset("rst0");
    // req0 alone, VAL held: one continuous 32-word frame
    ifc.IN1_VAL = 1'b0;
    cyc();
    chk("a_first_rdy", rdy0, 1'b1);
    chk("a_start", {ifc.SER_START, ifc.BUSY, ifc.OUT_VAL}, 3'b110);
    chk("a_ser_dr", ifc.SER_DR, 64'h0004_0003_0002_0001);
    cyc();
    chk("a_start_pulse", ifc.SER_START, 1'b0);
    run_until("a_acc", 8);
    ifc.IN0_VAL = 1'b0;
    flush("a");
    chk("a_cnt", vcnt, 32);
    chk("a_span", last_v - first_v + 1, 32);
    chk_log("a_log", 32'h0);
    // both valid: frames alternate req0, req1, req0 with no gap
    ifc.IN0_VAL = 1'b1;
    ifc.IN1_VAL = 1'b1;
    do_reset("rst_b");
    run_until("b_acc", 24);
    ifc.IN0_VAL = 1'b0;
    ifc.IN1_VAL = 1'b0;
    flush("b");
    chk("b_cnt", vcnt, 96);
    chk("b_span", last_v - first_v + 1, 96);
    chk_log("b_log", 32'h0000_FF00);
    // owner gap: req1 stays locked out until req0 finishes its frame
    ifc.IN0_VAL = 1'b1;
    ifc.IN1_VAL = 1'b1;
    do_reset("rst_c");
    run_until("c_acc4", 4);
    ifc.IN0_VAL = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("c_gap_rdy1", rdy1, 1'b0);
    end
    chk("c_gap_busy", {ifc.BUSY, ifc.OUT_VAL}, 2'b10);
    chk("c_gap_acc", acc_log.size(), 4);
    ifc.IN0_VAL = 1'b1;
    run_until("c_acc16", 16);
    ifc.IN0_VAL = 1'b0;
    ifc.IN1_VAL = 1'b0;
    flush("c");
    chk_log("c_log", 32'h0000_FF00);
    // HOLD for 6 cycles mid-frame
    ifc.IN0_VAL = 1'b1;
    do_reset("rst_d");
    run_until("d_acc3", 3);
    ifc.HOLD = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("d_hold_rdy", rdy0, 1'b0);
    end
    chk("d_hold_gap", ifc.OUT_VAL, 1'b0);
    chk("d_hold_acc", acc_log.size(), 3);
    ifc.HOLD = 1'b0;
    run_until("d_acc8", 8);
    ifc.IN0_VAL = 1'b0;
    flush("d");
    chk_log("d_log", 32'h0);
    // reset at beat 2 of group 5, then a clean restart from group 0
    ifc.IN0_VAL = 1'b1;
    do_reset("rst_e");
    run_until("e_acc6", 6);
    cyc();
    cyc();
    chk("e_mid_val", {ifc.OUT_VAL, ifc.BUSY}, 2'b11);
    do_reset("e_rst");
    cyc();
    chk("e_restart", {ifc.SER_START, ifc.SER_DR}, {1'b1, 64'h0004_0003_0002_0001});
    run_until("e_acc8", 8);
    ifc.IN0_VAL = 1'b0;
    flush("e");
    chk_log("e_log", 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
